// File: rtl/kernel_launcher_pkg.sv
// Shared definitions for the kernel launcher: FSM state encoding and the
// default parameter values used by kernel_launcher.
package kernel_launcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    EMIT   = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int DEF_CYC_WIDTH      = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/launch_cycle_counter.sv
// Saturating, synchronously clearable cycle counter used to time one kernel
// run.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : load zero (wins over en)
//   en         : count up by one, holding at all-ones
//   count      : current value
//   count_inc  : value count will take on the next enabled cycle (saturated)
module launch_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_inc
);

  assign count_inc = (&count) ? count : count + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count_inc;
  end

endmodule

// File: rtl/kernel_launcher.sv
// Batch launcher for a start/done style kernel. Accepts a command with a run
// count, launches the kernel that many times in sequence, and streams out one
// result per run (kernel output, run latency, run index). A watchdog aborts
// the batch if a run takes too long.
//   clk, rst                 : clock, asynchronous active-low reset
//   cmd_valid/ready/runs     : batch request
//   ap_start/ready/done      : kernel control handshake
//   kernel_out               : kernel result, sampled on ap_done
//   res_valid/ready/data/cycles/index : result stream
//   busy, batch_done, timeout : status
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int CYC_WIDTH      = DEF_CYC_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNT_WIDTH-1:0]  cmd_runs,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] kernel_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [CYC_WIDTH-1:0]  res_cycles,
  output logic [CNT_WIDTH-1:0]  res_index,
  output logic                  busy,
  output logic                  batch_done,
  output logic                  timeout
);

  localparam logic [CYC_WIDTH-1:0] TO_LIM = CYC_WIDTH'(TIMEOUT_CYCLES);

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   run_cnt, run_idx, run_idx_inc;
  logic [CYC_WIDTH-1:0]   cyc, cyc_inc;
  logic                   accept, launch_hs, done_run, to_hit, xfer, last;

  assign accept      = cmd_valid && (state == IDLE);
  assign launch_hs   = (state == LAUNCH) && ap_ready;
  assign done_run    = (state == RUN) && ap_done;
  // cyc_inc already counts the current RUN cycle, so it is the latency
  // including the ap_done cycle and reaches the limit on the Nth RUN cycle.
  assign to_hit      = (TIMEOUT_CYCLES != 0) && (state == RUN) && !ap_done &&
                       (cyc_inc >= TO_LIM);
  assign xfer        = (state == EMIT) && res_ready;
  assign run_idx_inc = run_idx + 1'b1;
  assign last        = (run_idx_inc == run_cnt);

  launch_cycle_counter #(.WIDTH(CYC_WIDTH)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (launch_hs),
    .en        (state == RUN),
    .count     (cyc),
    .count_inc (cyc_inc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && (cmd_runs != '0)) state_nxt = LAUNCH;
      LAUNCH:  if (ap_ready)                   state_nxt = RUN;
      RUN: begin
        if (ap_done)     state_nxt = EMIT;
        else if (to_hit) state_nxt = IDLE;
      end
      EMIT:    if (res_ready) state_nxt = last ? IDLE : LAUNCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    ap_start  = (state == LAUNCH);
    res_valid = (state == EMIT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt    <= '0;
      run_idx    <= '0;
      res_data   <= '0;
      res_cycles <= '0;
      res_index  <= '0;
      batch_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // Empty batch, last transfer, or watchdog abort all end the batch.
      batch_done <= (accept && (cmd_runs == '0)) || (xfer && last) || to_hit;
      if (accept)      timeout <= 1'b0;
      else if (to_hit) timeout <= 1'b1;
      if (accept && (cmd_runs != '0)) begin
        run_cnt <= cmd_runs;
        run_idx <= '0;
      end
      if (done_run) begin
        res_data   <= kernel_out;
        res_cycles <= cyc_inc;
        res_index  <= run_idx;
      end
      if (xfer) run_idx <= run_idx_inc;
    end
  end

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: a behavioural kernel pushes expected results to a
// scoreboard at each start handshake; a negedge monitor pops and compares on
// every result transfer and checks EMIT stability while stalled.
module tb_kernel_launcher;

  localparam int DW = 8, CW = 16, YW = 32, TO = 10, HANG = 1000;

  logic          clk = 1'b0, rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [CW-1:0] cmd_runs = '0;
  logic          ap_start, ap_ready, ap_done;
  logic [DW-1:0] kernel_out;
  logic          res_valid, res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic [YW-1:0] res_cycles;
  logic [CW-1:0] res_index;
  logic          busy, batch_done, timeout;

  always #5 clk = ~clk;

  kernel_launcher #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .CYC_WIDTH(YW),
                    .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_runs(cmd_runs), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .kernel_out(kernel_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_cycles(res_cycles),
    .res_index(res_index), .busy(busy), .batch_done(batch_done),
    .timeout(timeout)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // ---------------- kernel model + scoreboard producer ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [YW-1:0] c;
    logic [CW-1:0] i;
  } exp_t;
  exp_t sb[$];

  int            lat = 5, k_left = 0, n_hs = 0;
  logic          ready_en = 1'b1, k_abort = 1'b0;
  logic [CW-1:0] b_idx = '0;
  logic [DW-1:0] kout_r = '0;
  exp_t          e_push;

  assign ap_ready   = ready_en && (k_left == 0);
  assign ap_done    = (k_left == 1);
  assign kernel_out = ap_done ? kout_r : 8'hEE;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_left <= 0;
      b_idx  <= '0;
      sb.delete();
    end else begin
      if (cmd_valid && cmd_ready) b_idx <= '0;
      if (k_abort) k_left <= 0;
      else if (ap_start && ap_ready) begin
        k_left <= lat;
        kout_r <= DW'(8'h11 * (int'(b_idx) + 1));
        b_idx  <= b_idx + 1'b1;
        n_hs   <= n_hs + 1;
        if (lat < TO) begin
          e_push.d = DW'(8'h11 * (int'(b_idx) + 1));
          e_push.c = YW'(lat);
          e_push.i = b_idx;
          sb.push_back(e_push);
        end
      end else if (k_left > 0) k_left <= k_left - 1;
    end
  end

  // ---------------- monitor ----------------
  int            n_res = 0, n_bd = 0, n_start = 0, n_run = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] p_d;
  logic [YW-1:0] p_c;
  logic [CW-1:0] p_i;
  exp_t          e_pop;

  always @(negedge clk) begin
    if (!rst) stall_prev = 1'b0;
    else begin
      if (batch_done) n_bd++;
      if (ap_start) n_start++;
      if (busy && !ap_start && !res_valid) n_run++;
      if (stall_prev) begin
        chk("stall_vld", res_valid, 1);
        chk("stall_data", res_data, p_d);
        chk("stall_cyc", res_cycles, p_c);
        chk("stall_idx", res_index, p_i);
      end
      if (res_valid && res_ready) begin
        n_res++;
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e_pop = sb.pop_front();
          chk("res_data", res_data, e_pop.d);
          chk("res_cycles", res_cycles, e_pop.c);
          chk("res_index", res_index, e_pop.i);
        end
      end
      stall_prev = res_valid && !res_ready;
      p_d = res_data; p_c = res_cycles; p_i = res_index;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int runs);
    int t;
    step(1);
    cmd_valid = 1'b1;
    cmd_runs  = CW'(runs);
    t = 0;
    while (!cmd_ready && t < 100) begin step(1); t++; end
    chk("cmd_accept_wait", t < 100, 1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bd(input int base, input string tag);
    int t;
    t = 0;
    while (n_bd == base && t < 300) begin step(1); t++; end
    chk(tag, n_bd != base, 1);
  endtask

  int bd0, r0, s0, run0, h0, t;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_cycles", res_cycles, 0);
    chk("rst_res_index", res_index, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    step(2);

    // Three back-to-back runs, latency 5 each.
    bd0 = n_bd; r0 = n_res;
    send_cmd(3);
    wait_bd(bd0, "t1_bd_seen");
    step(3);
    chk("t1_nres", n_res - r0, 3);
    chk("t1_nbd", n_bd - bd0, 1);
    chk("t1_sb_left", sb.size(), 0);

    // Kernel not ready for 4 cycles: start held, no RUN cycles.
    ready_en = 1'b0; r0 = n_res; bd0 = n_bd;
    send_cmd(1);
    run0 = n_run;
    for (int i = 0; i < 4; i++) begin
      chk("t2_start_held", ap_start, 1);
      step(1);
    end
    chk("t2_no_run", n_run - run0, 0);
    ready_en = 1'b1;
    wait_bd(bd0, "t2_bd_seen");
    step(2);
    chk("t2_nres", n_res - r0, 1);

    // Result consumer stalls for 6 cycles.
    res_ready = 1'b0; r0 = n_res; bd0 = n_bd;
    send_cmd(2);
    t = 0;
    while (!res_valid && t < 100) begin step(1); t++; end
    chk("t3_res_valid_wait", t < 100, 1);
    s0 = n_start;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t3_vld_held", res_valid, 1);
      chk("t3_no_start", ap_start, 0);
    end
    chk("t3_no_start_cnt", n_start - s0, 0);
    res_ready = 1'b1;
    wait_bd(bd0, "t3_bd_seen");
    step(2);
    chk("t3_nres", n_res - r0, 2);

    // Kernel hangs: watchdog after 10 RUN cycles, rest of batch dropped.
    lat = HANG; r0 = n_res; bd0 = n_bd; run0 = n_run; h0 = n_hs;
    send_cmd(3);
    wait_bd(bd0, "t4_bd_seen");
    chk("t4_timeout", timeout, 1);
    chk("t4_run_cycles", n_run - run0, 10);
    step(6);
    chk("t4_nres", n_res - r0, 0);
    chk("t4_launches", n_hs - h0, 1);
    chk("t4_timeout_sticky", timeout, 1);
    chk("t4_nbd", n_bd - bd0, 1);
    k_abort = 1'b1; step(1); k_abort = 1'b0;
    lat = 5;

    // Empty batch: batch_done the cycle after acceptance, no launch.
    s0 = n_start; bd0 = n_bd;
    send_cmd(0);
    chk("t5_bd_next", batch_done, 1);
    chk("t5_timeout_clr", timeout, 0);
    step(1);
    chk("t5_bd_pulse", batch_done, 0);
    step(4);
    chk("t5_nstart", n_start - s0, 0);
    chk("t5_nbd", n_bd - bd0, 1);

    // Reset in RUN of run 1: everything cleared, no batch_done.
    h0 = n_hs; bd0 = n_bd; r0 = n_res;
    send_cmd(3);
    t = 0;
    while (n_hs < h0 + 2 && t < 100) begin step(1); t++; end
    chk("t6_second_launch", n_hs - h0, 2);
    step(1);
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ap_start", ap_start, 0);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_batch_done", batch_done, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_res_data", res_data, 0);
    chk("t6_res_cycles", res_cycles, 0);
    chk("t6_res_index", res_index, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    step(3);
    rst = 1'b1;
    step(10);
    chk("t6_no_bd", n_bd - bd0, 0);
    chk("t6_nres", n_res - r0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kernel_launcher.md
KERNEL_LAUNCHER -- requirements
Module: kernel_launcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the kernel result and the result stream.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the run count and the run index.
REQ-003 SHALL have parameter CYC_WIDTH, default 32: width of the per-run latency counter.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000: watchdog limit in RUN; 0 disables the watchdog.
REQ-005 SHALL have port clk  in  1  the single clock.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid  in  1  batch request valid.
REQ-008 SHALL have port cmd_ready  out  1  batch request accepted.
REQ-009 SHALL have port cmd_runs  in  CNT_WIDTH  number of kernel launches in the batch.
REQ-010 SHALL have port ap_start  out  1  kernel start request.
REQ-011 SHALL have port ap_ready  in  1  kernel idle, start accepted.
REQ-012 SHALL have port ap_done  in  1  one-cycle kernel completion pulse.
REQ-013 SHALL have port kernel_out  in  DATA_WIDTH  kernel result, valid while ap_done=1.
REQ-014 SHALL have port res_valid  out  1  result stream valid.
REQ-015 SHALL have port res_ready  in  1  result stream ready.
REQ-016 SHALL have port res_data  out  DATA_WIDTH  captured kernel_out.
REQ-017 SHALL have port res_cycles  out  CYC_WIDTH  latency of the run.
REQ-018 SHALL have port res_index  out  CNT_WIDTH  0-based run number within the batch.
REQ-019 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-020 SHALL have port batch_done  out  1  one-cycle pulse when a batch ends.
REQ-021 SHALL have port timeout  out  1  sticky watchdog flag, cleared on the next accepted command.

Function
REQ-022 SHALL implement the FSM states IDLE, LAUNCH, RUN and EMIT.
REQ-023 SHALL drive cmd_ready=1 only in IDLE; a command is accepted when cmd_valid&&cmd_ready.
REQ-024 SHALL, on acceptance with cmd_runs=0, stay in IDLE, pulse batch_done in the next cycle, and emit no result.
REQ-025 SHALL, on acceptance with cmd_runs>0, latch the run count, clear the run index, and go to LAUNCH.
REQ-026 SHALL drive ap_start=1 only in LAUNCH.
REQ-027 SHALL treat ap_start&&ap_ready at a rising edge as the start handshake, clear the latency counter, and go to RUN.
REQ-028 SHALL hold ap_start low from the cycle after the start handshake, so the kernel is never relaunched unintentionally.
REQ-029 SHALL, in RUN, increment the latency counter every cycle, saturating at all-ones.
REQ-030 SHALL measure res_cycles as the number of RUN cycles up to and including the ap_done cycle; the minimum value is 1.
REQ-031 SHALL, on ap_done in RUN, capture kernel_out, the latency and the run index, and go to EMIT.
REQ-032 SHALL ignore ap_done in any state other than RUN.
REQ-033 SHALL, in EMIT, hold res_valid=1 with stable res_data, res_cycles and res_index until res_valid&&res_ready.
REQ-034 SHALL, on the EMIT transfer, increment the run index; if it equals the latched count, go to IDLE and pulse batch_done, otherwise go to LAUNCH.
REQ-035 SHALL, when TIMEOUT_CYCLES>0 and the RUN latency counter reaches TIMEOUT_CYCLES without ap_done, set timeout, go to IDLE, pulse batch_done, and emit no result for that run.
REQ-036 SHALL abandon the remaining runs of the batch after a timeout.
REQ-037 SHALL drive res_valid=0 outside EMIT.

Reset
REQ-038 SHALL, while rst=0, force the FSM to IDLE, clear all counters, and drive ap_start=0, res_valid=0, batch_done=0, timeout=0 and busy=0.
REQ-039 SHALL clear res_data, res_cycles and res_index to 0 on reset.
REQ-040 SHALL, on reset asserted mid-batch, discard the batch immediately and produce no batch_done pulse.

Structure
REQ-041 SHALL take the FSM state enum typedef and the default parameter constants from a shared package, kernel_launcher_pkg.
REQ-042 SHALL place the saturating, clearable latency counter in a sub-module named launch_cycle_counter.

Verification
REQ-043 SHALL cover: cmd_runs=3, kernel returns done 5 cycles after start with out=0x11,0x22,0x33 -> three results, indices 0..2, res_cycles=5 each, one batch_done.
REQ-044 SHALL cover: ap_ready held low for 4 cycles in LAUNCH -> ap_start stays high, no RUN entry until ap_ready=1.
REQ-045 SHALL cover: res_ready low for 6 cycles in EMIT -> outputs stable, no new ap_start until the transfer.
REQ-046 SHALL cover: TIMEOUT_CYCLES=10, ap_done never asserted -> timeout=1 after 10 RUN cycles, batch_done pulse, no result.
REQ-047 SHALL cover: cmd_runs=0 -> batch_done one cycle after acceptance, ap_start never asserted.
REQ-048 SHALL cover: rst driven low in RUN of run 1 -> all outputs 0 and state IDLE immediately, with no batch_done.
